// File: rtl/uart_tx_frame_sched_pkg.sv
// Shared types and constants for the UART TX frame/status packet scheduler.
// Optional build macro: UART_TX_CHECKSUM_EN adds the trailing XOR checksum byte.
package uart_tx_pkg;

  localparam int unsigned FRAME_BYTES_DEF  = 5100;
  localparam logic [7:0]  SOF_BYTE_DEF     = 8'hA5;
  localparam logic [7:0]  TYPE_FRAME_DEF   = 8'h01;
  localparam logic [7:0]  TYPE_STATUS_DEF  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_TYPE,
    ST_PAYLOAD
`ifdef UART_TX_CHECKSUM_EN
    , ST_CSUM
`endif
  } state_e;

  typedef enum logic {
    KIND_FRAME,
    KIND_STATUS
  } kind_e;

endpackage

// File: rtl/uart_tx_frame_sched_tx_byte_stage.sv
// One-entry holding register for RAM read data that could not be pushed
// in the cycle it returned. A load in the same cycle as a pop replaces the entry.
module tx_byte_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       pop,
  output logic       valid,
  output logic [7:0] data
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;

  // Next-state for the entry: load has priority over pop.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // Entry register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/uart_tx_frame_sched.sv
// Packet scheduler sharing the UART TX FIFO push port between frame readout
// from the TX RAM and single-byte status packets. Packets are
// SOF, TYPE, payload[, checksum] and never interleave; status wins in IDLE.
// Optional build macro: UART_TX_CHECKSUM_EN (XOR of TYPE and payload appended).
module uart_tx_frame_sched
  import uart_tx_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = FRAME_BYTES_DEF,
  parameter logic [7:0]  SOF_BYTE    = SOF_BYTE_DEF,
  parameter logic [7:0]  TYPE_FRAME  = TYPE_FRAME_DEF,
  parameter logic [7:0]  TYPE_STATUS = TYPE_STATUS_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_done,
  output logic                           ram_re,
  output logic [$clog2(FRAME_BYTES)-1:0] ram_addr,
  input  logic [7:0]                     ram_rdata,
  output logic                           frame_ack,
  input  logic                           stat_valid,
  input  logic [7:0]                     stat_data,
  output logic                           stat_ready,
  input  logic                           tx_fifo_full,
  output logic                           push,
  output logic [7:0]                     tx_data
);

  localparam int unsigned AW = $clog2(FRAME_BYTES);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_BYTES - 1);

  state_e        state_q, state_d;
  kind_e         kind_q, kind_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] pcnt_q, pcnt_d;
  logic          rd_done_q, rd_done_d;
  logic          rvalid_q, rvalid_d;
  logic          frame_pend_q, frame_pend_d;
  logic [7:0]    stat_byte_q, stat_byte_d;
  logic          frame_ack_q, frame_ack_d;
`ifdef UART_TX_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic       stage_v;
  logic [7:0] stage_data;
  logic       stage_load;
  logic       stage_pop;
  logic       fr_push;
  logic [1:0] occ_next;
  logic [7:0] type_byte;
  logic [7:0] pay_byte;

  tx_byte_stage u_stage (
    .clk       (clk),
    .reset     (reset),
    .load      (stage_load),
    .load_data (ram_rdata),
    .pop       (stage_pop),
    .valid     (stage_v),
    .data      (stage_data)
  );

  // Packet sequencing, push decode and RAM read engine.
  // push/tx_data/ram_re/stat_ready are decoded combinationally from the
  // registered state so the FIFO full flag and the status handshake act in
  // the same cycle, and so one RAM byte per cycle is sustainable with a
  // single stage entry (RAM data may bypass the stage straight to the FIFO).
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    addr_d       = addr_q;
    pcnt_d       = pcnt_q;
    rd_done_d    = rd_done_q;
    rvalid_d     = 1'b0;
    stat_byte_d  = stat_byte_q;
    frame_ack_d  = 1'b0;
    frame_pend_d = frame_pend_q | frame_done;
`ifdef UART_TX_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    push         = 1'b0;
    tx_data      = '0;
    ram_re       = 1'b0;
    stat_ready   = 1'b0;
    stage_pop    = 1'b0;
    stage_load   = 1'b0;
    fr_push      = 1'b0;
    occ_next     = '0;
    type_byte    = (kind_q == KIND_FRAME) ? TYPE_FRAME : TYPE_STATUS;
    pay_byte     = stage_v ? stage_data : ram_rdata;

    case (state_q)
      ST_IDLE: begin
        if (stat_valid) begin
          stat_ready  = 1'b1;
          stat_byte_d = stat_data;
          kind_d      = KIND_STATUS;
          state_d     = ST_SOF;
          addr_d      = '0;
          pcnt_d      = '0;
          rd_done_d   = 1'b0;
        end else if (frame_pend_q) begin
          // A frame_done in this very cycle re-arms the pending flag.
          frame_pend_d = frame_done;
          kind_d       = KIND_FRAME;
          state_d      = ST_SOF;
          addr_d       = '0;
          pcnt_d       = '0;
          rd_done_d    = 1'b0;
        end
      end

      ST_SOF: begin
        tx_data = SOF_BYTE;
        if (!tx_fifo_full) begin
          push    = 1'b1;
          state_d = ST_TYPE;
        end
      end

      ST_TYPE: begin
        tx_data = type_byte;
        if (!tx_fifo_full) begin
          push    = 1'b1;
          state_d = ST_PAYLOAD;
`ifdef UART_TX_CHECKSUM_EN
          csum_d  = type_byte;
`endif
        end
      end

      ST_PAYLOAD: begin
        if (kind_q == KIND_STATUS) begin
          tx_data = stat_byte_q;
          if (!tx_fifo_full) begin
            push = 1'b1;
`ifdef UART_TX_CHECKSUM_EN
            csum_d  = csum_q ^ stat_byte_q;
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
`endif
          end
        end else begin
          tx_data = (stage_v | rvalid_q) ? pay_byte : '0;
          if ((stage_v | rvalid_q) && !tx_fifo_full) begin
            push    = 1'b1;
            fr_push = 1'b1;
            pcnt_d  = pcnt_q + AW'(1);
`ifdef UART_TX_CHECKSUM_EN
            csum_d  = csum_q ^ pay_byte;
`endif
            if (pcnt_q == LAST_IDX) begin
`ifdef UART_TX_CHECKSUM_EN
              state_d     = ST_CSUM;
`else
              state_d     = ST_IDLE;
              frame_ack_d = 1'b1;
`endif
            end
          end
        end
      end

`ifdef UART_TX_CHECKSUM_EN
      ST_CSUM: begin
        tx_data = csum_q;
        if (!tx_fifo_full) begin
          push        = 1'b1;
          state_d     = ST_IDLE;
          frame_ack_d = (kind_q == KIND_FRAME);
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // Read engine runs from TYPE onward so byte 0 is ready on PAYLOAD entry.
    // A read issues only if the stage will be empty after this cycle, which
    // guarantees room for the returning byte even if the FIFO stalls.
    stage_pop  = stage_v & fr_push;
    stage_load = rvalid_q & (stage_v | ~fr_push);
    occ_next   = {1'b0, stage_v} + {1'b0, rvalid_q} - {1'b0, fr_push};
    if ((kind_q == KIND_FRAME) && ((state_q == ST_TYPE) || (state_q == ST_PAYLOAD)) &&
        !rd_done_q && (occ_next == '0)) begin
      ram_re   = 1'b1;
      rvalid_d = 1'b1;
      if (addr_q == LAST_IDX) begin
        rd_done_d = 1'b1;
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end

    if (reset) begin
      push       = 1'b0;
      tx_data    = '0;
      ram_re     = 1'b0;
      stat_ready = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      kind_q       <= KIND_FRAME;
      addr_q       <= '0;
      pcnt_q       <= '0;
      rd_done_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      frame_pend_q <= 1'b0;
      stat_byte_q  <= '0;
      frame_ack_q  <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      addr_q       <= addr_d;
      pcnt_q       <= pcnt_d;
      rd_done_q    <= rd_done_d;
      rvalid_q     <= rvalid_d;
      frame_pend_q <= frame_pend_d;
      stat_byte_q  <= stat_byte_d;
      frame_ack_q  <= frame_ack_d;
`ifdef UART_TX_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign ram_addr  = addr_q;
  assign frame_ack = frame_ack_q;

endmodule

// File: tb/tb_uart_tx_frame_sched.sv
// Scoreboard bench for uart_tx_frame_sched: expected FIFO bytes are queued
// when stimulus is applied and compared as the DUT pushes them.
module tb_uart_tx_frame_sched;

  localparam int FB = 5100;
  localparam int AW = $clog2(FB);
`ifdef UART_TX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NST = 3 + CS;
  localparam int NFR = FB + 2 + CS;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_done;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata;
  logic          frame_ack;
  logic          stat_valid;
  logic [7:0]    stat_data;
  logic          stat_ready;
  logic          tx_fifo_full;
  logic          push;
  logic [7:0]    tx_data;
  logic          full_mode;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, push_cnt = 0, sr_cnt = 0, sr_cyc = -1, ack_cnt = 0, ack_cyc = -1;
  int last_push_cyc = -1, viol = 0, addr_viol = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_frame_sched #(.FRAME_BYTES(FB)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_done   (frame_done),
    .ram_re       (ram_re),
    .ram_addr     (ram_addr),
    .ram_rdata    (ram_rdata),
    .frame_ack    (frame_ack),
    .stat_valid   (stat_valid),
    .stat_data    (stat_data),
    .stat_ready   (stat_ready),
    .tx_fifo_full (tx_fifo_full),
    .push         (push),
    .tx_data      (tx_data)
  );

  // RAM model: RAM[i] = i[7:0], one-cycle read latency.
  always @(posedge clk) if (ram_re) ram_rdata <= ram_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_status(input logic [7:0] b);
    sb.push_back(8'hA5);
    sb.push_back(8'h02);
    sb.push_back(b);
    if (CS == 1) sb.push_back(8'h02 ^ b);
  endtask

  task automatic push_frame();
    logic [7:0] x;
    sb.push_back(8'hA5);
    sb.push_back(8'h01);
    x = 8'h01;
    for (int i = 0; i < FB; i++) begin
      sb.push_back(8'(i));
      x = x ^ 8'(i);
    end
    if (CS == 1) sb.push_back(x);
  endtask

  // One clock: sample/check at negedge, then step past the posedge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (push) begin
      if (tx_fifo_full) viol++;
      if (sb.size() == 0) begin
        chk("unexpected_push", 32'(push), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e));
      end
      push_cnt++;
      last_push_cyc = cyc;
    end
    if (stat_ready) begin sr_cnt++; sr_cyc = cyc; end
    if (frame_ack) begin ack_cnt++; ack_cyc = cyc; end
    if (ram_re && (int'(ram_addr) >= FB)) addr_viol++;
    @(posedge clk);
    #1;
    cyc++;
    tx_fifo_full = full_mode && (((cyc / 3) % 2) == 1);
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int k = 0;
    while (push_cnt < target && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_timeout"}, 32'(push_cnt >= target), 32'd1);
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  initial begin
    int p0, s0, a0, c0, k;
    reset = 1'b1; frame_done = 1'b0; stat_valid = 1'b0; stat_data = '0;
    tx_fifo_full = 1'b0; full_mode = 1'b0;
    repeat (3) tick();
    chk("rst_push", 32'(push), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_ram_re", 32'(ram_re), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_frame_ack", 32'(frame_ack), 0);
    chk("rst_stat_ready", 32'(stat_ready), 0);
    reset = 1'b0;
    tick();

    // Status packet alone.
    p0 = push_cnt; s0 = sr_cnt;
    stat_valid = 1'b1; stat_data = 8'h3C;
    push_status(8'h3C);
    tick();
    stat_valid = 1'b0;
    run_until(p0 + NST, 20, "st1");
    repeat (3) tick();
    chk("st1_ready_pulses", 32'(sr_cnt - s0), 1);
    chk("st1_span", 32'(last_push_cyc - sr_cyc), 32'(NST));

    // Frame packet, FIFO never full.
    p0 = push_cnt; a0 = ack_cnt; c0 = cyc;
    push_frame();
    pulse_frame_done();
    run_until(p0 + NFR, FB + 100, "fr1");
    repeat (3) tick();
    chk("fr1_span", 32'(last_push_cyc - c0), 32'(NFR + 1));
    chk("fr1_ack_cnt", 32'(ack_cnt - a0), 1);
    chk("fr1_ack_cycle", 32'(ack_cyc), 32'(last_push_cyc + 1));
    chk("fr1_addr_end", 32'(ram_addr), 32'(FB - 1));

    // Frame packet with FIFO full toggling every 3 cycles.
    p0 = push_cnt;
    full_mode = 1'b1;
    push_frame();
    pulse_frame_done();
    run_until(p0 + NFR, 3 * FB, "fr2");
    full_mode = 1'b0;
    repeat (5) tick();
    chk("fr2_push_total", 32'(push_cnt - p0), 32'(NFR));
    chk("fr2_sb_empty", 32'(sb.size()), 0);

    // Status request during frame payload waits for the frame to finish.
    p0 = push_cnt; s0 = sr_cnt;
    push_frame();
    pulse_frame_done();
    run_until(p0 + 102, 200, "fr3_mid");
    stat_valid = 1'b1; stat_data = 8'h5A;
    push_status(8'h5A);
    k = 0;
    while (sr_cnt == s0 && k < FB + 100) begin
      tick();
      k++;
    end
    stat_valid = 1'b0;
    chk("st3_ready_seen", 32'(sr_cnt - s0), 1);
    chk("st3_after_frame", 32'(sr_cyc), 32'(ack_cyc));
    run_until(p0 + NFR + NST, 50, "st3");
    repeat (3) tick();

    // frame_done and stat_valid together: status first.
    p0 = push_cnt; a0 = ack_cnt;
    stat_valid = 1'b1; stat_data = 8'hC3; frame_done = 1'b1;
    push_status(8'hC3);
    push_frame();
    tick();
    stat_valid = 1'b0; frame_done = 1'b0;
    run_until(p0 + NST + NFR, FB + 100, "both");
    repeat (3) tick();
    chk("both_ack_cnt", 32'(ack_cnt - a0), 1);

    // Reset mid-payload, with a frame re-pended before the reset.
    p0 = push_cnt;
    push_frame();
    pulse_frame_done();
    run_until(p0 + 1002, 1200, "rst_a");
    pulse_frame_done();
    run_until(p0 + 2002, 1200, "rst_b");
    reset = 1'b1;
    tick();
    chk("rst_mid_push", 32'(push), 0);
    chk("rst_mid_addr", 32'(ram_addr), 0);
    chk("rst_mid_ram_re", 32'(ram_re), 0);
    sb.delete();
    tick();
    reset = 1'b0;
    p0 = push_cnt;
    repeat (10) tick();
    chk("rst_pend_cleared", 32'(push_cnt - p0), 0);
    push_frame();
    pulse_frame_done();
    run_until(p0 + NFR, FB + 100, "rst_restart");
    repeat (3) tick();
    chk("end_sb_empty", 32'(sb.size()), 0);
    chk("push_while_full", 32'(viol), 0);
    chk("addr_range", 32'(addr_viol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
